// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped write-back cache controller: hit service, dirty-victim write-back, line allocate.
// Optional CACHE_PERF_CNT_EN adds hit_cnt_o / miss_cnt_o.
`timescale 1ns/1ps
module cache_ctrl_fsm #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned TAG_W  = 18,
   parameter int unsigned LINE_W = 128,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cpu_req_valid_i,
   input  logic                 cpu_req_rw_i,
   input  logic [31:0]          cpu_req_addr_i,
   input  logic [31:0]          cpu_req_data_i,
   output logic [31:0]          cpu_res_data_o,
   output logic                 cpu_res_ready_o,
   output logic [IDX_W:0]       tag_req_o,
   output logic [TAG_W+1:0]     tag_write_o,
   input  logic [TAG_W+1:0]     tag_read_i,
   output logic [IDX_W:0]       data_req_o,
   output logic [LINE_W-1:0]    data_write_o,
   input  logic [LINE_W-1:0]    data_read_i,
   output logic                 mem_req_valid_o,
   output logic                 mem_req_rw_o,
   output logic [31:0]          mem_req_addr_o,
   output logic [LINE_W-1:0]    mem_req_data_o,
   input  logic [LINE_W-1:0]    mem_data_i,
   input  logic                 mem_ready_i
`ifdef CACHE_PERF_CNT_EN
   ,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
`endif
);

   localparam int unsigned WORDS  = LINE_W / 32;
   localparam int unsigned WORD_W = $clog2(WORDS);
   localparam int unsigned OFF_W  = 2 + WORD_W;

   typedef enum logic [1:0] {IDLE, CMP, WB, ALLOC} state_t;

   state_t              state, next_state;
   logic [31:2]         req_addr;
   logic [31:0]         req_data;
   logic                req_rw;
   logic [TAG_W-1:0]    victim_tag;
   logic [LINE_W-1:0]   victim_line;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_index;
   logic [WORD_W-1:0]   req_word;
   logic                tag_valid, tag_dirty, hit;
   logic [TAG_W-1:0]    stored_tag;
   logic [31:0]         rd_word;
   logic [LINE_W-1:0]   merged_line;
   logic                tag_we, data_we;
   logic                unused_addr;

   assign unused_addr = ^cpu_req_addr_i[1:0];

   assign req_tag    = req_addr[31 -: TAG_W];
   assign req_index  = req_addr[OFF_W +: IDX_W];
   assign req_word   = req_addr[2 +: WORD_W];
   assign tag_valid  = tag_read_i[TAG_W+1];
   assign tag_dirty  = tag_read_i[TAG_W];
   assign stored_tag = tag_read_i[TAG_W-1:0];
   assign hit        = tag_valid && (stored_tag == req_tag);

   assign tag_req_o  = {tag_we, req_index};
   assign data_req_o = {data_we, req_index};

   always_comb begin
      rd_word     = '0;
      merged_line = data_read_i;
      for (int unsigned w = 0; w < WORDS; w++) begin
         if (req_word == w[WORD_W-1:0]) begin
            rd_word             = data_read_i[w*32 +: 32];
            merged_line[w*32 +: 32] = req_data;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         req_addr    <= '0;
         req_data    <= '0;
         req_rw      <= 1'b0;
         victim_tag  <= '0;
         victim_line <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && cpu_req_valid_i) begin
            req_addr <= cpu_req_addr_i[31:2];
            req_data <= cpu_req_data_i;
            req_rw   <= cpu_req_rw_i;
         end
         // The victim must be captured now: ALLOC overwrites the array entry.
         if (state == CMP && !hit && tag_valid && tag_dirty) begin
            victim_tag  <= stored_tag;
            victim_line <= data_read_i;
         end
      end
   end

   always_comb begin
      next_state      = state;
      cpu_res_data_o  = '0;
      cpu_res_ready_o = 1'b0;
      tag_we          = 1'b0;
      tag_write_o     = '0;
      data_we         = 1'b0;
      data_write_o    = '0;
      mem_req_valid_o = 1'b0;
      mem_req_rw_o    = 1'b0;
      mem_req_addr_o  = '0;
      mem_req_data_o  = '0;
      unique case (state)
         IDLE: begin
            if (cpu_req_valid_i) next_state = CMP;
         end
         CMP: begin
            if (hit) begin
               cpu_res_ready_o = 1'b1;
               next_state      = IDLE;
               if (req_rw) begin
                  data_we      = 1'b1;
                  data_write_o = merged_line;
                  tag_we       = 1'b1;
                  tag_write_o  = {1'b1, 1'b1, req_tag};
               end else begin
                  cpu_res_data_o = rd_word;
               end
            end else if (tag_valid && tag_dirty) begin
               next_state = WB;
            end else begin
               next_state = ALLOC;
            end
         end
         WB: begin
            mem_req_valid_o = 1'b1;
            mem_req_rw_o    = 1'b1;
            mem_req_addr_o  = {victim_tag, req_index, {OFF_W{1'b0}}};
            mem_req_data_o  = victim_line;
            if (mem_ready_i) next_state = ALLOC;
         end
         ALLOC: begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = {req_tag, req_index, {OFF_W{1'b0}}};
            if (mem_ready_i) begin
               data_we      = 1'b1;
               data_write_o = mem_data_i;
               tag_we       = 1'b1;
               tag_write_o  = {1'b1, 1'b0, req_tag};
               next_state   = CMP;
            end
         end
         default: next_state = IDLE;
      endcase
   end

`ifdef CACHE_PERF_CNT_EN
   // refill marks the compare that follows a fill so it is not counted as a hit.
   logic refill;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         refill     <= 1'b0;
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (state == ALLOC && mem_ready_i) refill <= 1'b1;
         else if (state == CMP)             refill <= 1'b0;
         if (state == CMP && hit && !refill) hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (state == CMP && !hit)           miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Randomized self-checking bench for cache_ctrl_fsm against an architectural memory model.
`timescale 1ns/1ps
module tb_cache_ctrl_fsm;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_valid, cpu_rw;
   logic [31:0]   cpu_addr, cpu_wdata;
   logic [31:0]   cpu_rdata;
   logic          cpu_ready;
   logic [10:0]   tag_req, data_req;
   logic [19:0]   tag_write, tag_read;
   logic [127:0]  data_write, data_read;
   logic          mem_valid, mem_rw, mem_ready;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_wdata, mem_rdata;
`ifdef CACHE_PERF_CNT_EN
   logic [31:0]   hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   cache_ctrl_fsm #(.DEPTH(1024), .TAG_W(18), .LINE_W(128)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cpu_req_valid_i(cpu_valid), .cpu_req_rw_i(cpu_rw),
      .cpu_req_addr_i(cpu_addr), .cpu_req_data_i(cpu_wdata),
      .cpu_res_data_o(cpu_rdata), .cpu_res_ready_o(cpu_ready),
      .tag_req_o(tag_req), .tag_write_o(tag_write), .tag_read_i(tag_read),
      .data_req_o(data_req), .data_write_o(data_write), .data_read_i(data_read),
      .mem_req_valid_o(mem_valid), .mem_req_rw_o(mem_rw),
      .mem_req_addr_o(mem_addr), .mem_req_data_o(mem_wdata),
      .mem_data_i(mem_rdata), .mem_ready_i(mem_ready)
`ifdef CACHE_PERF_CNT_EN
      , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
   );

   // Tag and data arrays: combinational read, write on the clock edge.
   logic [19:0]  tag_mem  [1024];
   logic [127:0] data_mem [1024];
   assign tag_read  = tag_mem[tag_req[9:0]];
   assign data_read = data_mem[data_req[9:0]];
   always @(posedge clk) begin
      if (tag_req[10])  tag_mem[tag_req[9:0]]   <= tag_write;
      if (data_req[10]) data_mem[data_req[9:0]] <= data_write;
   end

   // Reference: architectural memory as the CPU sees it, main memory, and cache residency.
   logic [31:0]  arch_mem [logic [31:0]];
   logic [127:0] main_mem [logic [31:0]];
   bit           m_valid [1024];
   bit           m_dirty [1024];
   logic [17:0]  m_tag   [1024];

   int unsigned checks = 0, errors = 0;
   int unsigned exp_hits = 0, exp_misses = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [31:0] arch_read(input logic [31:0] a);
      if (arch_mem.exists(a)) return arch_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [127:0] arch_line(input logic [31:0] la);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = arch_read(la + 32'(k*4));
      return l;
   endfunction

   function automatic logic [127:0] main_line(input logic [31:0] la);
      logic [127:0] l;
      if (main_mem.exists(la)) return main_mem[la];
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = init_word(la + 32'(k*4));
      return l;
   endfunction

   // Memory responder: random 0..3 wait cycles per operation, logs each completed op.
   typedef struct {
      bit           rw;
      logic [31:0]  addr;
      logic [127:0] data;
      int unsigned  lat;
   } mem_op_t;
   mem_op_t     mem_log [$];
   bit          mem_hold = 1'b0;
   int unsigned wait_cnt = 0, waited = 0;

   initial begin
      mem_op_t op;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         mem_rdata = '0;
         if (rst_n && mem_valid && !mem_hold) begin
            if (wait_cnt == 0) begin
               op.rw   = mem_rw;
               op.addr = mem_addr;
               op.lat  = waited + 1;
               if (mem_rw) begin
                  main_mem[mem_addr] = mem_wdata;
                  op.data = mem_wdata;
               end else begin
                  mem_rdata = main_line(mem_addr);
                  op.data = mem_rdata;
               end
               mem_ready = 1'b1;
               mem_log.push_back(op);
               waited   = 0;
               wait_cnt = $urandom_range(0, 3);
            end else begin
               wait_cnt--;
               waited++;
            end
         end
      end
   end

   task automatic do_req(input bit rw, input logic [31:0] addr, input logic [31:0] wdata);
      logic [9:0]   idx;
      logic [17:0]  tg;
      bit           exp_hit, exp_wb, got_ready;
      logic [31:0]  victim_addr, rdata;
      logic [127:0] victim_line;
      int unsigned  n_ops, cycles, lat_sum;
      idx = addr[13:4];
      tg  = addr[31:14];
      exp_hit     = m_valid[idx] && (m_tag[idx] == tg);
      exp_wb      = !exp_hit && m_valid[idx] && m_dirty[idx];
      victim_addr = {m_tag[idx], idx, 4'h0};
      victim_line = arch_line(victim_addr);
      n_ops       = exp_hit ? 0 : (exp_wb ? 2 : 1);
      mem_log.delete();

      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_rw    = rw;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cycles    = 0;
      got_ready = 1'b0;
      rdata     = '0;
      while (!got_ready && cycles < 100) begin
         @(negedge clk);
         cycles++;
         if (cpu_ready) begin
            got_ready = 1'b1;
            rdata     = cpu_rdata;
         end
      end
      cpu_valid = 1'b0;
      check("ready_seen", 128'(got_ready), 128'd1);
      check("mem_op_count", 128'(mem_log.size()), 128'(n_ops));
      lat_sum = 0;
      if (mem_log.size() == n_ops) begin
         for (int i = 0; i < int'(n_ops); i++) begin
            lat_sum += mem_log[i].lat;
            if (exp_wb && i == 0) begin
               check("wb_rw",   128'(mem_log[i].rw), 128'd1);
               check("wb_addr", 128'(mem_log[i].addr), 128'(victim_addr));
               check("wb_data", mem_log[i].data, victim_line);
            end else begin
               check("fill_rw",   128'(mem_log[i].rw), 128'd0);
               check("fill_addr", 128'(mem_log[i].addr), 128'({tg, idx, 4'h0}));
            end
         end
      end
      check("latency", 128'(cycles), 128'(exp_hit ? 1 : 2 + lat_sum));
      if (!rw) check("read_data", 128'(rdata), 128'(arch_read(addr)));

      if (exp_hit) exp_hits++;
      else         exp_misses++;
      if (!exp_hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_dirty[idx] = 1'b0;
      end
      if (rw) begin
         arch_mem[addr] = wdata;
         m_dirty[idx]   = 1'b1;
      end

      @(negedge clk);
      check("ready_pulse", 128'(cpu_ready), 128'd0);
      check("rdata_idle", 128'(cpu_rdata), 128'd0);
      check("tag_entry", 128'(tag_mem[idx]), 128'({1'b1, m_dirty[idx], tg}));
`ifdef CACHE_PERF_CNT_EN
      check("hit_cnt",  128'(hit_cnt),  128'(exp_hits));
      check("miss_cnt", 128'(miss_cnt), 128'(exp_misses));
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) begin
         tag_mem[i]  = '0;
         data_mem[i] = '0;
         m_valid[i]  = 1'b0;
         m_dirty[i]  = 1'b0;
         m_tag[i]    = '0;
      end
      rst_n = 1'b0;
      cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      #1;
      check("rst_ready",     128'(cpu_ready), 128'd0);
      check("rst_rdata",     128'(cpu_rdata), 128'd0);
      check("rst_mem_valid", 128'(mem_valid), 128'd0);
      check("rst_tag_req",   128'(tag_req),   128'd0);
      check("rst_data_req",  128'(data_req),  128'd0);
      check("rst_mem_addr",  128'(mem_addr),  128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_req(1'b0, 32'h0000_1234, 32'h0);
      do_req(1'b0, 32'h0000_1238, 32'h0);
      do_req(1'b1, 32'h0000_1230, 32'hDEAD_BEEF);
      do_req(1'b0, 32'h0000_1230, 32'h0);
      do_req(1'b0, 32'h0000_5230, 32'h0);

      // Reset while a fill is outstanding.
      mem_hold = 1'b1;
      @(negedge clk);
      cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0001_6000;
      @(negedge clk);
      cpu_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("alloc_valid", 128'(mem_valid), 128'd1);
      check("alloc_rw",    128'(mem_rw),    128'd0);
      check("alloc_addr",  128'(mem_addr),  128'h0001_6000);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mem_valid", 128'(mem_valid), 128'd0);
      check("async_rst_tag_req",   128'(tag_req),   128'd0);
      check("async_rst_ready",     128'(cpu_ready), 128'd0);
      exp_hits = 0;
      exp_misses = 0;
`ifdef CACHE_PERF_CNT_EN
      check("async_rst_hit_cnt",  128'(hit_cnt),  128'd0);
      check("async_rst_miss_cnt", 128'(miss_cnt), 128'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      mem_hold = 1'b0;
      @(negedge clk);
      check("post_rst_mem_valid", 128'(mem_valid), 128'd0);
      do_req(1'b0, 32'h0001_6000, 32'h0);

      for (int n = 0; n < 300; n++) begin
         a = '0;
         a[31:14] = 18'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: a[13:4] = 10'h123;
            1: a[13:4] = 10'h124;
            2: a[13:4] = 10'h3FF;
            3: a[13:4] = 10'h000;
            default: a[13:4] = 10'h200;
         endcase
         a[3:2] = 2'($urandom_range(0, 3));
         do_req(1'($urandom_range(0, 1)), a, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
